// File: rtl/otter_pkg.sv
// Shared types for the OTTER handshake control unit: opcodes, FSM states, fault codes.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_LD_WAIT,
        ST_ST_WAIT,
        ST_WB,
        ST_TRAP,
        ST_FAULT
    } state_t;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FC_NONE     = 2'b00;
    localparam fault_code_t FC_ILLEGAL  = 2'b01;
    localparam fault_code_t FC_FETCH_TO = 2'b10;
    localparam fault_code_t FC_DATA_TO  = 2'b11;

endpackage

// File: rtl/otter_wait_timer.sv
// Counts consecutive ready-low cycles of a pending memory request; expired flags the
// last permitted cycle. WAIT_TIMEOUT of 0 never expires.
module otter_wait_timer #(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW_RAW = $clog2(WAIT_TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (WAIT_TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/otter_cu_fsm_hs.sv
// OTTER multicycle control FSM with ready handshakes, wait timeout, sticky fault and instret.
// Define OTTER_INTR_EN to enable interrupt entry (TRAP) and CSR writes on SYSTEM.
module otter_cu_fsm_hs
    import otter_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int INSTRET_W    = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [6:0]           ir_op,
    input  logic [2:0]           func3,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 intr,
    input  logic                 csr_mie,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 mem_read1,
    output logic                 mem_read2,
    output logic                 csr_write,
    output logic                 intr_taken,
    output logic                 err,
    output logic [1:0]           fault_code,
    output logic [INSTRET_W-1:0] instret
);

    state_t      state;
    state_t      nxt;
    fault_code_t fault_nxt;
    logic        retire;
    logic        trap_req;
    logic        tmr_run;
    logic        tmr_expired;

    // The timer only advances while a request is outstanding; any other cycle resets it.
    assign tmr_run = ((state == ST_FETCH) && !imem_ready)
                  || ((state == ST_LD_WAIT || state == ST_ST_WAIT) && !dmem_ready);

    otter_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clear   (!tmr_run),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

`ifdef OTTER_INTR_EN
    assign trap_req = intr && csr_mie;
`else
    assign trap_req = 1'b0;
    logic unused_in;
    assign unused_in = ^{func3, intr, csr_mie};
`endif

    always_comb begin
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_read1  = 1'b0;
        mem_read2  = 1'b0;
        csr_write  = 1'b0;
        intr_taken = 1'b0;
        retire     = 1'b0;
        nxt        = state;
        fault_nxt  = fault_code;
        case (state)
            ST_FETCH: begin
                mem_read1 = 1'b1;
                if (imem_ready) begin
                    nxt = ST_EXEC;
                end else if (tmr_expired) begin
                    nxt       = ST_FAULT;
                    fault_nxt = FC_FETCH_TO;
                end
            end
            ST_EXEC: begin
                case (ir_op)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG, OP_IMM: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_LOAD: begin
                        mem_read2 = 1'b1;
                        nxt       = dmem_ready ? ST_WB : ST_LD_WAIT;
                    end
                    OP_STORE: begin
                        mem_write = 1'b1;
                        if (dmem_ready) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end else begin
                            nxt = ST_ST_WAIT;
                        end
                    end
                    OP_SYSTEM: begin
`ifdef OTTER_INTR_EN
                        // func3 of zero is mret: no register or CSR update.
                        reg_write = (func3 != 3'b000);
                        csr_write = (func3 != 3'b000);
`endif
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
                        nxt       = ST_FAULT;
                        fault_nxt = FC_ILLEGAL;
                    end
                endcase
            end
            ST_LD_WAIT: begin
                mem_read2 = 1'b1;
                if (dmem_ready) begin
                    nxt = ST_WB;
                end else if (tmr_expired) begin
                    nxt       = ST_FAULT;
                    fault_nxt = FC_DATA_TO;
                end
            end
            ST_ST_WAIT: begin
                mem_write = 1'b1;
                if (dmem_ready) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end else if (tmr_expired) begin
                    nxt       = ST_FAULT;
                    fault_nxt = FC_DATA_TO;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
`ifdef OTTER_INTR_EN
            ST_TRAP: begin
                intr_taken = 1'b1;
                pc_write   = 1'b1;
                nxt        = ST_FETCH;
            end
`endif
            ST_FAULT: nxt = ST_FAULT;
            default:  nxt = ST_FETCH;
        endcase
        if (retire) begin
            nxt = trap_req ? ST_TRAP : ST_FETCH;
        end
        // Enables stay low for the whole time reset is held.
        if (!RST_N) begin
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            mem_read1  = 1'b0;
            mem_read2  = 1'b0;
            csr_write  = 1'b0;
            intr_taken = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_FETCH;
            instret    <= '0;
            err        <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state      <= nxt;
            fault_code <= fault_nxt;
            if (nxt == ST_FAULT) begin
                err <= 1'b1;
            end
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

endmodule
